mem_copy_engine: RTL

- Sequencer directly upstream of the data memory. It drives the memory's read-enable, write-enable, address and write-data inputs, and consumes its read data.
- The processor control issues one copy command: source base, destination base and byte count. The engine then moves the block byte-by-byte through the memory's single port.
- Typical use: staging FEC codeword buffers, such as copying raw message bytes into an encode working area.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_copy_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine.
//   ADDR_W / DATA_W : memory address and data widths
//   addr_t / data_t : address and data word types
//   copy_state_t    : copy sequencer states
package mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Single-port memory block copy sequencer: moves `length` bytes from
// src_base to dst_base one byte at a time (READ then WRITE per byte),
// ascending addresses with ADDR_W-bit wrap.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             command strobe, sampled only in IDLE
//   src_base/dst_base first source/destination address
//   length            byte count (0 = no transfer)
//   busy, done        status (done is a one-cycle pulse)
//   mem_read_en, mem_write_en, mem_address, mem_data_out  memory controls
//   mem_data_in       combinational memory read data
//   checksum          XOR of bytes written by the last command
//                     (present only when COPY_CHECKSUM_EN is defined)
module mem_copy_engine
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  copy_state_t state_q, state_nx;
  addr_t       src_q, src_nx;
  addr_t       dst_q, dst_nx;
  addr_t       len_q, len_nx;
  addr_t       idx_q, idx_nx;
  data_t       hold_q, hold_nx;
  logic        busy_nx, done_nx, rd_nx, wr_nx;
  addr_t       addr_nx;
  addr_t       idx_inc;
`ifdef COPY_CHECKSUM_EN
  data_t       chk_q, chk_nx;
  assign checksum = chk_q;
`endif

  assign idx_inc = ADDR_W'(idx_q + ADDR_W'(1));

  // The holding register drives the write data bus directly.
  assign mem_data_out = hold_q;

  // Register all state, datapath and memory-control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_address  <= '0;
`ifdef COPY_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_nx;
      src_q        <= src_nx;
      dst_q        <= dst_nx;
      len_q        <= len_nx;
      idx_q        <= idx_nx;
      hold_q       <= hold_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      mem_read_en  <= rd_nx;
      mem_write_en <= wr_nx;
      mem_address  <= addr_nx;
`ifdef COPY_CHECKSUM_EN
      chk_q        <= chk_nx;
`endif
    end
  end

  // Next state plus next values of the registered outputs, so each output
  // lines up with the state it belongs to.
  always_comb begin
    state_nx = state_q;
    src_nx   = src_q;
    dst_nx   = dst_q;
    len_nx   = len_q;
    idx_nx   = idx_q;
    hold_nx  = hold_q;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    rd_nx    = 1'b0;
    wr_nx    = 1'b0;
    addr_nx  = mem_address;
`ifdef COPY_CHECKSUM_EN
    chk_nx   = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_nx = src_base;
          dst_nx = dst_base;
          len_nx = length;
          idx_nx = '0;
`ifdef COPY_CHECKSUM_EN
          chk_nx = '0;
`endif
          if (length == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = READ;
            rd_nx    = 1'b1;
            busy_nx  = 1'b1;
            addr_nx  = src_base;
          end
        end
      end
      READ: begin
        hold_nx  = mem_data_in;
        state_nx = WRITE;
        wr_nx    = 1'b1;
        busy_nx  = 1'b1;
        addr_nx  = ADDR_W'(dst_q + idx_q);
      end
      WRITE: begin
        idx_nx = idx_inc;
`ifdef COPY_CHECKSUM_EN
        chk_nx = chk_q ^ hold_q;
`endif
        if (idx_inc == len_q) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx = READ;
          rd_nx    = 1'b1;
          busy_nx  = 1'b1;
          addr_nx  = ADDR_W'(src_q + idx_inc);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
